// File: rtl/pulp_cg_pkg.sv
// Shared types and defaults for the pulp clock-gating controller.
// Channel FSM encodings also appear as plain localparams for legacy-style state registers.
package pulp_cg_pkg;

  localparam int unsigned CG_CNT_W_DEF  = 8;
  localparam int unsigned CG_STAT_W_DEF = 32;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_GATED = 2'd1,
    CG_WAKE  = 2'd2
  } cg_state_e;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_GATED = 2'd1;
  localparam logic [1:0] ST_WAKE  = 2'd2;

endpackage

// File: rtl/pulp_clock_gate_ctrl_chan_fsm.sv
// One gating channel: RUN/GATED/WAKE FSM, idle counter, wake ack and flopped ICG enable.
// With CG_STATS_EN defined, also counts cycles spent in GATED.
module cg_chan_fsm
  import pulp_cg_pkg::*;
#(
  parameter int unsigned CNT_W  = CG_CNT_W_DEF,
  parameter int unsigned STAT_W = CG_STAT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_en_i,
  input  logic [CNT_W-1:0]  cfg_idle_i,
  input  logic              busy_i,
  input  logic              wake_req_i,
`ifdef CG_STATS_EN
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_cnt_o,
`endif
  output logic              en_o,
  output logic              gated_o,
  output logic              wake_ack_o
);

  logic [1:0]       state_q, state_next;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_next;
  logic             en_q, en_next;
  logic             gated_q;
  logic             ack_q, ack_next;
  logic             idle, wake_cond, thr_hit;

  always_comb begin
    idle      = cfg_en_i & ~busy_i & ~wake_req_i & (|cfg_idle_i);
    wake_cond = busy_i | wake_req_i | ~cfg_en_i | ~(|cfg_idle_i);
    // Extra bit keeps the +1 from wrapping when the counter is saturated.
    thr_hit   = (({1'b0, idle_cnt_q}) + (CNT_W+1)'(1)) >= {1'b0, cfg_idle_i};

    state_next    = state_q;
    idle_cnt_next = idle_cnt_q;
    en_next       = en_q;

    case (state_q)
      ST_RUN: begin
        if (idle) begin
          if (thr_hit) begin
            state_next    = ST_GATED;
            en_next       = 1'b0;
            idle_cnt_next = '0;
          end else if (!(&idle_cnt_q)) begin
            idle_cnt_next = idle_cnt_q + CNT_W'(1);
          end
        end else begin
          idle_cnt_next = '0;
        end
      end
      ST_GATED: begin
        if (wake_cond) begin
          state_next = ST_WAKE;
          en_next    = 1'b1;
        end
      end
      ST_WAKE: begin
        state_next    = ST_RUN;
        idle_cnt_next = '0;
      end
      default: begin
        state_next    = ST_RUN;
        en_next       = 1'b1;
        idle_cnt_next = '0;
      end
    endcase

    ack_next = ack_q;
    if (!wake_req_i)              ack_next = 1'b0;
    else if (state_next == ST_RUN) ack_next = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= '0;
      en_q       <= 1'b1;
      gated_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_next;
      idle_cnt_q <= idle_cnt_next;
      en_q       <= en_next;
      gated_q    <= ~en_next;
      ack_q      <= ack_next;
    end
  end

  assign en_o       = en_q;
  assign gated_o    = gated_q;
  assign wake_ack_o = ack_q;

`ifdef CG_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else if (stat_clr_i) begin
      stat_q <= '0;
    end else if ((state_q == ST_GATED) && !(&stat_q)) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign stat_cnt_o = stat_q;
`endif

endmodule

// File: rtl/pulp_clock_gate_ctrl_icg.sv
// Behavioural model of the library integrated clock-gating cell (CK/EN/SE/CKG).
// The enable latch is transparent while CK is low, so CKG never glitches.
module pulp_cg_icg (
  input  logic CK,
  input  logic EN,
  input  logic SE,
  output logic CKG
);

  logic en_latch;

  always_latch begin
    if (!CK) en_latch = EN | SE;
  end

  assign CKG = CK & en_latch;

endmodule

// File: rtl/pulp_clock_gate_ctrl.sv
// Multi-channel autonomous clock-gating controller: NCH channel FSMs each driving one ICG.
// Optional per-channel gated-cycle statistics are enabled with the CG_STATS_EN macro.
module pulp_clock_gate_ctrl
  import pulp_cg_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CNT_W  = CG_CNT_W_DEF,
  parameter int unsigned STAT_W = CG_STAT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic [NCH-1:0]        cfg_en_i,
  input  logic [CNT_W-1:0]      cfg_idle_i,
  input  logic [NCH-1:0]        busy_i,
  input  logic [NCH-1:0]        wake_req_i,
  output logic [NCH-1:0]        wake_ack_o,
  output logic [NCH-1:0]        gated_o,
`ifdef CG_STATS_EN
  input  logic                  stat_clr_i,
  output logic [NCH*STAT_W-1:0] stat_cnt_o,
`endif
  output logic [NCH-1:0]        clk_o
);

  logic [NCH-1:0] en_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    cg_chan_fsm #(
      .CNT_W  (CNT_W),
      .STAT_W (STAT_W)
    ) u_fsm (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cfg_en_i   (cfg_en_i[gi]),
      .cfg_idle_i (cfg_idle_i),
      .busy_i     (busy_i[gi]),
      .wake_req_i (wake_req_i[gi]),
`ifdef CG_STATS_EN
      .stat_clr_i (stat_clr_i),
      .stat_cnt_o (stat_cnt_o[gi*STAT_W +: STAT_W]),
`endif
      .en_o       (en_q[gi]),
      .gated_o    (gated_o[gi]),
      .wake_ack_o (wake_ack_o[gi])
    );

    pulp_cg_icg u_icg (
      .CK  (clk_i),
      .EN  (en_q[gi]),
      .SE  (test_en_i),
      .CKG (clk_o[gi])
    );
  end

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Directed self-checking bench for pulp_clock_gate_ctrl (NCH=4, CNT_W=8).
// Gated-clock activity is measured by counting rising edges of each clk_o bit.
module tb_pulp_clock_gate_ctrl;

  localparam int NCH    = 4;
  localparam int CNT_W  = 8;
  localparam int STAT_W = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  test_en;
  logic [NCH-1:0]        cfg_en;
  logic [CNT_W-1:0]      cfg_idle;
  logic [NCH-1:0]        busy;
  logic [NCH-1:0]        wake_req;
  logic [NCH-1:0]        wake_ack;
  logic [NCH-1:0]        gated;
  logic [NCH-1:0]        clk_g;
`ifdef CG_STATS_EN
  logic                  stat_clr;
  logic [NCH*STAT_W-1:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int edge_cnt [NCH];
  int snap     [NCH];

  pulp_clock_gate_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .test_en_i  (test_en),
    .cfg_en_i   (cfg_en),
    .cfg_idle_i (cfg_idle),
    .busy_i     (busy),
    .wake_req_i (wake_req),
    .wake_ack_o (wake_ack),
    .gated_o    (gated),
`ifdef CG_STATS_EN
    .stat_clr_i (stat_clr),
    .stat_cnt_o (stat_cnt),
`endif
    .clk_o      (clk_g)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_mon
    initial edge_cnt[gi] = 0;
    always @(posedge clk_g[gi]) edge_cnt[gi] = edge_cnt[gi] + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < NCH; i++) snap[i] = edge_cnt[i];
  endtask

  task automatic check_edges(input string name, input logic [NCH-1:0] mask, input int exp_on);
    for (int i = 0; i < NCH; i++) begin
      int exp_v;
      exp_v = mask[i] ? exp_on : 0;
      checks++;
      if ((edge_cnt[i] - snap[i]) !== exp_v) begin
        errors++;
        $display("FAIL %s ch%0d clk_o edges got %0d exp %0d", name, i, edge_cnt[i] - snap[i], exp_v);
      end
    end
  endtask

  task automatic check_gated(input string name, input logic [NCH-1:0] exp_v);
    checks++;
    if (gated !== exp_v) begin
      errors++;
      $display("FAIL %s gated_o got %b exp %b", name, gated, exp_v);
    end else $display("check %s gated_o=%b", name, gated);
  endtask

  task automatic check_ack(input string name, input logic [NCH-1:0] exp_v);
    checks++;
    if (wake_ack !== exp_v) begin
      errors++;
      $display("FAIL %s wake_ack_o got %b exp %b", name, wake_ack, exp_v);
    end else $display("check %s wake_ack_o=%b", name, wake_ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; test_en = 1'b0; cfg_en = '1; cfg_idle = 8'd4;
    busy = '0; wake_req = '0;
`ifdef CG_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(2);
    check_gated("reset", 4'b0000);
    check_ack("reset", 4'b0000);
    rst_n = 1'b1;
    take_snap();
    tick(3);
    check_gated("idle3", 4'b0000);
    tick(1);
    check_gated("idle4_gate", 4'b1111);
    check_edges("run_before_gate", 4'b1111, 4);
    take_snap();
    tick(3);
    check_edges("flat_when_gated", 4'b1111, 0);
  endtask

  task automatic test_busy_wake();
    busy = 4'b0010;
    tick(1);
    busy = '0;
    check_gated("busy1_wake", 4'b1101);
    take_snap();
    tick(2);
    check_edges("ch1_running", 4'b0010, 2);
    tick(2);
    check_gated("ch1_counting", 4'b1101);
    tick(1);
    check_gated("ch1_regated", 4'b1111);
  endtask

  task automatic test_wake_handshake();
    wake_req = 4'b0100;
    tick(1);
    check_ack("req_edge1", 4'b0000);
    check_gated("req_edge1", 4'b1011);
    tick(1);
    check_ack("req_edge2", 4'b0100);
    tick(2);
    check_ack("req_held", 4'b0100);
    check_gated("req_held", 4'b1011);
    wake_req = '0;
    tick(1);
    check_ack("req_drop", 4'b0000);
    tick(2);
    check_gated("post_req_idle3", 4'b1011);
    tick(1);
    check_gated("post_req_regate", 4'b1111);
  endtask

  task automatic test_threshold();
    cfg_idle = 8'd10;
    busy = '1;
    tick(1);
    busy = '0;
    tick(1);
    for (int r = 0; r < 3; r++) begin
      tick(5);
      check_gated("thr10_idle5", 4'b0000);
      busy = '1;
      tick(1);
      busy = '0;
      check_gated("thr10_busy", 4'b0000);
    end
    tick(5);
    check_gated("thr10_idle5_last", 4'b0000);
    cfg_idle = 8'd3;
    tick(1);
    check_gated("thr_lowered", 4'b1111);
  endtask

  task automatic test_collision();
    cfg_idle = 8'd4;
    busy = '1;
    tick(1);
    busy = '0;
    tick(1);
    tick(3);
    check_gated("coll_pre", 4'b0000);
    wake_req = 4'b0001;
    tick(1);
    check_gated("coll_hit", 4'b1110);
    check_ack("run_ack_lat1", 4'b0001);
    wake_req = '0;
    cfg_idle = 8'd1;
    tick(1);
    check_ack("run_ack_drop", 4'b0000);
    check_gated("thr1_gate", 4'b1111);
  endtask

  task automatic test_test_en_reset();
    test_en = 1'b1;
    take_snap();
    tick(3);
    check_edges("test_en_run", 4'b1111, 3);
    check_gated("test_en", 4'b1111);
    test_en = 1'b0;
    tick(1);
    take_snap();
    tick(2);
    check_edges("test_en_off", 4'b1111, 0);
    rst_n = 1'b0;
    #1;
    check_gated("async_rst", 4'b0000);
    take_snap();
    tick(2);
    check_edges("rst_clk_run", 4'b1111, 2);
    rst_n = 1'b1;
    tick(1);
    check_gated("after_rst_thr1", 4'b1111);
  endtask

`ifdef CG_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    tick(100);
    checks++;
    if (stat_cnt[31:0] !== 32'd100) begin
      errors++;
      $display("FAIL stat_100 got %0d exp 100", stat_cnt[31:0]);
    end else $display("check stat_100 cnt=%0d", stat_cnt[31:0]);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    checks++;
    if (stat_cnt !== '0) begin
      errors++;
      $display("FAIL stat_clr got %h exp 0", stat_cnt);
    end else $display("check stat_clr cnt=0");
  endtask
`endif

  initial begin
    test_reset();
    test_busy_wake();
    test_wake_handshake();
    test_threshold();
    test_collision();
    test_test_en_reset();
`ifdef CG_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
